// File: rtl/ws2812b_chain_ctrl.sv
// Frame sequencer for a WS2812B chain: CPU-written GRB pixel buffer streamed to the
// serializer on a start command, followed by a latch (reset) interval on the line.
module ws2812b_chain_ctrl #(
  parameter int CLK_FREQ = 20_000_000,
  parameter int NUM_LEDS = 8,
  parameter int LATCH_US = 300,
  localparam int AW = $clog2(NUM_LEDS) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sel,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          ready,
  output logic [23:0]   px_data,
  output logic          px_ena,
  input  logic          px_can_accept
);

  localparam int LATCH_CYCLES = (CLK_FREQ / 1_000_000) * LATCH_US;
  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [AW-1:0] CTRL_BIT   = AW'(1) << (AW - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_LEDS - 1);
  localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, LATCH} state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx, idx_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [15:0]   frame_count, frame_count_next;
  logic [23:0]   pix_buf [NUM_LEDS];

  logic          busy;
  logic          ctrl_sel;
  logic          pix_hit;
  logic          wr_en;
  logic          start;
  logic [AW-1:0] pix_addr;
  logic          unused_wdata;

  assign ctrl_sel     = addr[AW-1];
  assign pix_addr     = addr & ~CTRL_BIT;
  assign pix_hit      = ~ctrl_sel & ({1'b0, pix_addr} < (AW+1)'(NUM_LEDS));
  assign busy         = (state != IDLE);
  // Only pixel writes stall: the buffer is streamed in place, so it must not change mid-frame.
  assign ready        = sel & ~(busy & we & ~ctrl_sel);
  assign wr_en        = sel & we & ready;
  assign start        = wr_en & ctrl_sel & wdata[0];
  assign px_data      = pix_buf[idx];
  assign unused_wdata = ^wdata[31:24];

  always_comb begin
    rdata = '0;
    if (ctrl_sel) begin
      rdata = {frame_count, 14'd0, busy, 1'b0};
    end else if (pix_hit) begin
      rdata = {8'd0, pix_buf[pix_addr[IW-1:0]]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        pix_buf[i] <= '0;
      end
    end else if (wr_en & pix_hit) begin
      pix_buf[pix_addr[IW-1:0]] <= wdata[23:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      frame_count <= '0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      cnt         <= cnt_next;
      frame_count <= frame_count_next;
    end
  end

  always_comb begin
    state_next       = state;
    idx_next         = idx;
    cnt_next         = cnt;
    frame_count_next = frame_count;
    px_ena           = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SEND;
          idx_next   = '0;
        end
      end
      SEND: begin
        px_ena = px_can_accept;
        if (px_can_accept) begin
          if (idx == LAST_IDX) begin
            state_next = DRAIN;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      // can_accept returning high means the last pixel has left the shifter.
      DRAIN: begin
        if (px_can_accept) begin
          state_next = LATCH;
          cnt_next   = LATCH_LOAD;
        end
      end
      LATCH: begin
        if (cnt == '0) begin
          state_next       = IDLE;
          frame_count_next = frame_count + 16'd1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
